// File: rtl/tile_run_ctrl.sv
// Tile run controller: synchronises the board reset, holds harts in reset for a
// programmable number of cycles, then runs them until all are done or a timeout.
module tile_run_ctrl #(
    parameter int NUM_HARTS       = 1,
    parameter int RST_HOLD_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 10000,
    parameter int CNT_W           = 32
) (
    input  logic                 CLK100MHZ,
    input  logic                 ck_rst,
    input  logic                 restart,
    input  logic [NUM_HARTS-1:0] hart_done,
    input  logic [NUM_HARTS-1:0] hart_pass,
    output logic [NUM_HARTS-1:0] hart_rst,
    output logic                 running,
    output logic                 finished,
    output logic                 timeout,
    output logic                 pass,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [NUM_HARTS-1:0] done_mask
);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam int              HW        = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic            TO_EN     = (TIMEOUT_CYCLES != 0);

    logic [1:0]           r_sync;
    logic                 w_rst_sync;
    logic [1:0]           r_state;
    logic [HW-1:0]        r_hold_cnt;
    logic [CNT_W-1:0]     r_cycle_count;
    logic [NUM_HARTS-1:0] r_done_mask;
    logic                 r_fail;
    logic [NUM_HARTS-1:0] r_hart_rst;
    logic                 r_running;
    logic                 r_finished;
    logic                 r_timeout;
    logic                 r_pass;

    logic [1:0]           w_state_nxt;
    logic [HW-1:0]        w_hold_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [NUM_HARTS-1:0] w_mask_nxt;
    logic                 w_fail_nxt;

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], 1'b0};
    end

    assign w_rst_sync = r_sync[1];

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_cnt_nxt   = r_cycle_count;
        w_mask_nxt  = r_done_mask;
        w_fail_nxt  = r_fail;
        if (restart) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = '0;
            w_cnt_nxt   = '0;
            w_mask_nxt  = '0;
            w_fail_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = S_RUN;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    if (r_cycle_count != '1) w_cnt_nxt = r_cycle_count + CNT_W'(1);
                    w_mask_nxt = r_done_mask | hart_done;
                    // Only a hart's first done report counts towards pass/fail.
                    w_fail_nxt = r_fail | (|(hart_done & ~r_done_mask & ~hart_pass));
                    if (&w_mask_nxt)                         w_state_nxt = S_DONE;
                    else if (TO_EN && r_cycle_count == TO_LAST) w_state_nxt = S_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst || w_rst_sync) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_done_mask   <= '0;
            r_fail        <= 1'b0;
            r_hart_rst    <= '1;
            r_running     <= 1'b0;
            r_finished    <= 1'b0;
            r_timeout     <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_cycle_count <= w_cnt_nxt;
            r_done_mask   <= w_mask_nxt;
            r_fail        <= w_fail_nxt;
            // Outputs decoded from the next state so they change on the transition edge.
            r_hart_rst    <= {NUM_HARTS{w_state_nxt != S_RUN}};
            r_running     <= (w_state_nxt == S_RUN);
            r_finished    <= (w_state_nxt == S_DONE) || (w_state_nxt == S_TIMEOUT);
            r_timeout     <= (w_state_nxt == S_TIMEOUT);
            r_pass        <= (w_state_nxt == S_DONE) && !w_fail_nxt;
        end
    end

    assign hart_rst    = r_hart_rst;
    assign running     = r_running;
    assign finished    = r_finished;
    assign timeout     = r_timeout;
    assign pass        = r_pass;
    assign cycle_count = r_cycle_count;
    assign done_mask   = r_done_mask;

endmodule

// File: doc/tile_run_ctrl.md
# tile_run_ctrl

Run controller for a multi-hart tile: synchronises the board reset, holds every hart in reset for a programmable number of cycles, then runs them while counting cycles and collecting per-hart completion and pass/fail. Ends the run on all-harts-done or a cycle timeout, and supports soft restart. It is the synthesizable, parametrised successor to the fixed reset-hold / run-N-cycles sequencing used around `Tile`. It sits between the board clock/reset pins and the hart reset inputs.

## Interface
- `NUM_HARTS`, default 1: number of harts controlled; must be ≥1.
- `RST_HOLD_CYCLES`, default 2: cycles `hart_rst` stays asserted after synchronised reset release or restart; must be ≥1.
- `TIMEOUT_CYCLES`, default 10000: run length limit in cycles; 0 disables the timeout.
- `CNT_W`, default 32: width of `cycle_count`.

- `CLK100MHZ`  in   1          sole clock, rising edge.
- `ck_rst`     in   1          reset; asynchronous, active-low.
- `restart`    in   1          soft restart request; single-cycle pulse; honoured in any state.
- `hart_done`  in   NUM_HARTS  per-hart completion; level or pulse.
- `hart_pass`  in   NUM_HARTS  per-hart result; valid only in cycles where the matching `hart_done` bit is 1.
- `hart_rst`   out  NUM_HARTS  synchronous active-high reset to each hart.
- `running`    out  1          1 in RUN.
- `finished`   out  1          1 in DONE or TIMEOUT.
- `timeout`    out  1          1 in TIMEOUT.
- `pass`       out  1          1 in DONE when no hart reported fail.
- `cycle_count` out CNT_W      number of RUN cycles completed.
- `done_mask`  out  NUM_HARTS  sticky per-hart done flags.

## Operation
- **Reset synchroniser:** two flops. Asserting `ck_rst` low forces `rst_sync=1` immediately. Releasing it lets `rst_sync` fall on the 2nd rising edge after release. All other state is reset asynchronously by `ck_rst` and held while `rst_sync=1`.
- **Reset values:** `hart_rst` all 1s; `running`, `finished`, `timeout`, `pass` = 0; `cycle_count` = 0; `done_mask` = 0; state = HOLD; hold counter = 0; internal `fail` = 0.
- **FSM states:** HOLD, RUN, DONE, TIMEOUT.
- **HOLD:**
  - `hart_rst` all 1s.
  - Hold counter increments each cycle with `rst_sync=0`.
  - When the counter equals `RST_HOLD_CYCLES-1`, the next state is RUN.
- **RUN:**
  - `hart_rst` all 0s, `running=1`.
  - `cycle_count` increments each cycle and saturates at 2^CNT_W−1.
  - `done_mask <= done_mask | hart_done`.
  - On the first cycle a bit of `hart_done` is seen, if `hart_pass` for that bit is 0, `fail` is set (sticky).
  - Later `hart_done` assertions on an already-done hart are ignored for pass/fail.
- **RUN exits:**
  - If `(done_mask | hart_done)` is all 1s, next state is DONE.
  - Otherwise, if `TIMEOUT_CYCLES≠0` and `cycle_count == TIMEOUT_CYCLES-1`, next state is TIMEOUT.
  - Completion wins over timeout in the same cycle.
- **DONE:** `finished=1`, `pass=~fail`, `hart_rst` all 1s (harts parked). `cycle_count` and `done_mask` are frozen. `hart_done` is ignored.
- **TIMEOUT:** `finished=1`, `timeout=1`, `pass=0`, `hart_rst` all 1s, counters frozen.
- **restart:** in any state with `rst_sync=0`, the next state is HOLD. The hold counter, `cycle_count`, `done_mask` and `fail` clear on the same edge. `restart` during HOLD restarts the hold count. `restart` beats every other transition.
- **Reset mid-run:** `ck_rst` low at any time returns all outputs to reset values asynchronously. A new hold sequence starts after release.

## Timing
- All outputs are registered, driven from FSM state and counters; there are no combinational input-to-output paths.
- Edge E0 = first rising edge with `rst_sync=0`. `hart_rst` deasserts on edge E0+`RST_HOLD_CYCLES`.
- `running` rises on the same edge as `hart_rst` deasserts.
- `hart_done` sampled at edge E sets `done_mask` and, if it completes the set, moves the FSM to DONE on edge E. `finished` is visible after edge E, and `hart_rst` re-asserts on edge E.
- Timeout: with `TIMEOUT_CYCLES=T`, TIMEOUT is entered on the edge that increments `cycle_count` to T. `cycle_count` reads T in TIMEOUT.
- Soft restart: after a `restart` pulse sampled at edge R, `hart_rst` deasserts at edge R+`RST_HOLD_CYCLES`.

## Test plan
- **Basic release:** `NUM_HARTS=1`, `RST_HOLD_CYCLES=2`. Hold `ck_rst`=0 for 3 cycles, then release. Expect `hart_rst`=1 until the 4th rising edge after release, then `running=1` and `cycle_count` incrementing from 0.
- **Pass/fail, NUM_HARTS=4:**
  - Pulse done on harts 0..3 at distinct cycles, all with `hart_pass=1`. Expect DONE, `pass=1`, `done_mask=4'hF`, `cycle_count` frozen.
  - Repeat with hart 2 `hart_pass=0`. Expect `pass=0`.
- **Timeout:** `TIMEOUT_CYCLES=10000`, no `hart_done`. Expect `timeout=1`, `finished=1`, `pass=0`, `cycle_count=10000`. `TIMEOUT_CYCLES=0` never times out within 20000 cycles.
- **Simultaneous events:** the last `hart_done` arrives in the cycle where `cycle_count=T-1`. Expect DONE, not TIMEOUT. `restart` in the same cycle as completion: expect HOLD.
- **Soft restart:** pulse `restart` mid-RUN at `cycle_count=500`, and again in DONE. Expect counters and `done_mask` cleared, `hart_rst` high for exactly `RST_HOLD_CYCLES` cycles, then RUN again.
- **Async reset mid-run:** pull `ck_rst` low between clock edges during RUN. Expect all outputs at reset values before the next edge. After release, expect the full synchroniser-plus-hold sequence repeated.
